// File: rtl/dpc_pkg.sv
// Shared types and instruction-field layout for the datapath controller.
// Build option DPC_TRAP_EN adds the S_ERR trap state for illegal opcodes.
package dpc_pkg;

    localparam int INSTR_W = 16;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 13;
    localparam int OP_HI   = 12;
    localparam int OP_LO   = 11;
    localparam int RN_HI   = 10;
    localparam int RN_LO   = 8;
    localparam int RD_HI   = 7;
    localparam int RD_LO   = 5;
    localparam int SH_HI   = 4;
    localparam int SH_LO   = 3;
    localparam int RM_HI   = 2;
    localparam int RM_LO   = 0;
    localparam int IMM8_HI = 7;
    localparam int IMM5_HI = 4;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] VSEL_REG = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_CALC,
        S_WRIMM,
        S_WRREG
`ifdef DPC_TRAP_EN
        , S_ERR
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MOVI,
        CLS_MOVR,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN
    } instr_cls_t;

    typedef struct packed {
        logic [2:0] rn;
        logic [2:0] rd;
        logic [2:0] rm;
        logic [1:0] op;
        logic [1:0] sh;
    } fields_t;

endpackage

// File: rtl/datapath_ctrl_if.sv
// Start/instruction handshake plus datapath strobes between controller and datapath.
// The err signal exists only when DPC_TRAP_EN is defined.
interface datapath_ctrl_if;
    logic        start;
    logic [15:0] instr;
    logic        busy;
    logic        done;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
`ifdef DPC_TRAP_EN
    logic        err;

    modport master (
        input  start, instr,
        output busy, done, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8, sximm5, err
    );
    modport slave (
        output start, instr,
        input  busy, done, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8, sximm5, err
    );
`else
    modport master (
        input  start, instr,
        output busy, done, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8, sximm5
    );
    modport slave (
        output start, instr,
        input  busy, done, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8, sximm5
    );
`endif
endinterface

// File: rtl/dpc_decode.sv
// Combinational field extraction, opcode classification and immediate sign extension.
module dpc_decode
    import dpc_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output fields_t            fields,
    output instr_cls_t         cls,
    output logic [15:0]        sximm8,
    output logic [15:0]        sximm5
);

    logic [2:0] opc;

    always_comb begin
        opc       = ir[OPC_HI:OPC_LO];
        fields.rn = ir[RN_HI:RN_LO];
        fields.rd = ir[RD_HI:RD_LO];
        fields.rm = ir[RM_HI:RM_LO];
        fields.op = ir[OP_HI:OP_LO];
        fields.sh = ir[SH_HI:SH_LO];

        cls = CLS_ILLEGAL;
        if (opc == OPC_MOV) begin
            if (fields.op == OP_MOVI) begin
                cls = CLS_MOVI;
            end else if (fields.op == OP_MOVR) begin
                cls = CLS_MOVR;
            end
        end else if (opc == OPC_ALU) begin
            case (fields.op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end

        sximm8 = {{(16-IMM8_HI-1){ir[IMM8_HI]}}, ir[IMM8_HI:0]};
        sximm5 = {{(16-IMM5_HI-1){ir[IMM5_HI]}}, ir[IMM5_HI:0]};
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle controller sequencing register reads, ALU and writeback for one instruction.
// With DPC_TRAP_EN defined, illegal opcodes lock into S_ERR (err=1) until reset; otherwise they act as a NOP.
module datapath_ctrl
    import dpc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    datapath_ctrl_if.master bus
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    fields_t    f;
    instr_cls_t cls;
    logic [15:0] sximm8, sximm5;

    logic       busy, done, write, loada, loadb, loadc, loads, asel;
    logic [2:0] readnum, writenum;
    logic [1:0] vsel, shift, alu_op;

    dpc_decode u_decode (
        .ir     (ir_q),
        .fields (f),
        .cls    (cls),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // All outputs depend on the registered state and IR only.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        busy     = (state_q != S_WAIT);
        done     = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = VSEL_REG;
        shift    = 2'b00;
        alu_op   = 2'b00;

        case (state_q)
            S_WAIT: begin
                if (bus.start) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOVI:                   state_d = S_WRIMM;
                    CLS_MOVR, CLS_MVN:          state_d = S_GETB;
                    CLS_ADD, CLS_CMP, CLS_AND:  state_d = S_GETA;
                    default: begin
`ifdef DPC_TRAP_EN
                        state_d = S_ERR;
`else
                        done    = 1'b1;
                        state_d = S_WAIT;
`endif
                    end
                endcase
            end
            S_GETA: begin
                readnum = f.rn;
                loada   = 1'b1;
                state_d = S_GETB;
            end
            S_GETB: begin
                readnum = f.rm;
                loadb   = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                // MOVR passes B through the ALU with A forced to zero.
                shift  = f.sh;
                asel   = (cls == CLS_MOVR);
                alu_op = asel ? 2'b00 : f.op;
                if (cls == CLS_CMP) begin
                    loads   = 1'b1;
                    done    = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WRREG;
                end
            end
            S_WRREG: begin
                write    = 1'b1;
                writenum = f.rd;
                done     = 1'b1;
                state_d  = S_WAIT;
            end
            S_WRIMM: begin
                write    = 1'b1;
                writenum = f.rn;
                vsel     = VSEL_IMM;
                done     = 1'b1;
                state_d  = S_WAIT;
            end
`ifdef DPC_TRAP_EN
            S_ERR: begin
                state_d = S_ERR;
            end
`endif
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.readnum  = readnum;
    assign bus.writenum = writenum;
    assign bus.write    = write;
    assign bus.loada    = loada;
    assign bus.loadb    = loadb;
    assign bus.loadc    = loadc;
    assign bus.loads    = loads;
    assign bus.asel     = asel;
    assign bus.bsel     = 1'b0;
    assign bus.vsel     = vsel;
    assign bus.shift    = shift;
    assign bus.ALUop    = alu_op;
    assign bus.sximm8   = sximm8;
    assign bus.sximm5   = sximm5;
`ifdef DPC_TRAP_EN
    assign bus.err      = (state_q == S_ERR);
`endif

endmodule
